// File: rtl/dpram_access_ctrl.sv
// dpram_access_ctrl: two request ports serialized onto one 2^ADDR_W x DATA_W storage array.
// Latency: write Done 2 cycles after the strobe edge is sampled, read Done RD_LAT+2; contention adds one access.
// Backpressure: none; one read and one write may be pending per port, further edges are dropped and set Overrun.
// Ports: clk/ar (sync active-high reset); port 0 = A, DIn, RD, WR -> DOut, Done;
//        port B = B_A, B_DIn, B_RD, B_WR -> B_DOut, B_Done; Busy = activity, Overrun = sticky drop flag.
module dpram_access_ctrl #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              ar,
   input  logic [ADDR_W-1:0] A,
   input  logic [DATA_W-1:0] DIn,
   input  logic              RD,
   input  logic              WR,
   output logic [DATA_W-1:0] DOut,
   output logic              Done,
   input  logic [ADDR_W-1:0] B_A,
   input  logic [DATA_W-1:0] B_DIn,
   input  logic              B_RD,
   input  logic              B_WR,
   output logic [DATA_W-1:0] B_DOut,
   output logic              B_Done,
   output logic              Busy,
   output logic              Overrun
);

   typedef enum logic [2:0] {IDLE, WR_ISSUE, RD_ISSUE, RD_WAIT, RD_DONE} state_t;
   localparam int CNT_W = 2;

   // Index 0 = port 0, index 1 = port B throughout.
   logic [ADDR_W-1:0] a_s       [2];
   logic [DATA_W-1:0] din_s     [2];
   logic [ADDR_W-1:0] rd_addr_q [2];
   logic [ADDR_W-1:0] wr_addr_q [2];
   logic [DATA_W-1:0] wr_data_q [2];

   logic [1:0] rd_s, wr_s, rd_q, wr_q;
   logic [1:0] rd_req, wr_req, rd_clr, wr_clr;
   logic [1:0] rd_pend_q, wr_pend_q;
   logic       overrun_q;

   state_t            state_q;
   logic              port_q;
   logic              last_grant_q;
   logic [CNT_W-1:0]  cnt_q;

   logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
   logic [DATA_W-1:0] mem_rdata_q;

   logic any0, any1, gnt_vld, gnt_port, gnt_wr;

   assign a_s[0]   = A;
   assign a_s[1]   = B_A;
   assign din_s[0] = DIn;
   assign din_s[1] = B_DIn;
   assign rd_s     = {B_RD, RD};
   assign wr_s     = {B_WR, WR};
   assign rd_req   = rd_s & ~rd_q;
   assign wr_req   = wr_s & ~wr_q;

   // Pending bits retire on the same edge that raises the port's Done.
   always_comb begin
      rd_clr = '0;
      wr_clr = '0;
      if (state_q == WR_ISSUE)
         wr_clr[port_q] = 1'b1;
      if (state_q == RD_WAIT && cnt_q == '0)
         rd_clr[port_q] = 1'b1;
   end

   // Round-robin between ports on a tie; within a port the write goes first
   // so a simultaneous RD+WR edge reads back the freshly written word.
   assign any0     = rd_pend_q[0] | wr_pend_q[0];
   assign any1     = rd_pend_q[1] | wr_pend_q[1];
   assign gnt_vld  = any0 | any1;
   assign gnt_port = (any0 & any1) ? ~last_grant_q : any1;
   assign gnt_wr   = wr_pend_q[gnt_port];

   // Edge detect, pending bookkeeping and the sticky overrun flag.
   always_ff @(posedge clk) begin
      if (ar) begin
         rd_q      <= '0;
         wr_q      <= '0;
         rd_pend_q <= '0;
         wr_pend_q <= '0;
         overrun_q <= 1'b0;
      end else begin
         rd_q      <= rd_s;
         wr_q      <= wr_s;
         rd_pend_q <= (rd_pend_q & ~rd_clr) | (rd_req & ~rd_pend_q);
         wr_pend_q <= (wr_pend_q & ~wr_clr) | (wr_req & ~wr_pend_q);
         if ((|(rd_req & rd_pend_q)) | (|(wr_req & wr_pend_q)))
            overrun_q <= 1'b1;
      end
   end

   // Request registers only load when the request is accepted, so they stay
   // stable for the whole access regardless of later input changes.
   always_ff @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
         if (rd_req[p] && !rd_pend_q[p])
            rd_addr_q[p] <= a_s[p];
         if (wr_req[p] && !wr_pend_q[p]) begin
            wr_addr_q[p] <= a_s[p];
            wr_data_q[p] <= din_s[p];
         end
      end
   end

   // Storage array: not reset; a write is suppressed if ar lands on its issue edge.
   always_ff @(posedge clk) begin
      if (!ar && state_q == WR_ISSUE)
         mem_q[wr_addr_q[port_q]] <= wr_data_q[port_q];
      if (state_q == RD_ISSUE)
         mem_rdata_q <= mem_q[rd_addr_q[port_q]];
   end

   // Access sequencer. RD_DONE is the cycle in which the read completion is
   // visible; it arbitrates like IDLE so back-to-back accesses lose no cycle.
   always_ff @(posedge clk) begin
      if (ar) begin
         state_q      <= IDLE;
         port_q       <= 1'b0;
         last_grant_q <= 1'b1;
         cnt_q        <= '0;
         DOut         <= '0;
         B_DOut       <= '0;
         Done         <= 1'b0;
         B_Done       <= 1'b0;
      end else begin
         Done   <= 1'b0;
         B_Done <= 1'b0;
         case (state_q)
            IDLE, RD_DONE: begin
               if (gnt_vld) begin
                  port_q       <= gnt_port;
                  last_grant_q <= gnt_port;
                  state_q      <= gnt_wr ? WR_ISSUE : RD_ISSUE;
               end else begin
                  state_q <= IDLE;
               end
            end
            WR_ISSUE: begin
               if (port_q) B_Done <= 1'b1;
               else        Done   <= 1'b1;
               state_q <= IDLE;
            end
            RD_ISSUE: begin
               cnt_q   <= CNT_W'(RD_LAT - 1);
               state_q <= RD_WAIT;
            end
            RD_WAIT: begin
               if (cnt_q == '0) begin
                  if (port_q) begin
                     B_DOut <= mem_rdata_q;
                     B_Done <= 1'b1;
                  end else begin
                     DOut <= mem_rdata_q;
                     Done <= 1'b1;
                  end
                  state_q <= RD_DONE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign Busy    = (state_q != IDLE) | (|rd_pend_q) | (|wr_pend_q);
   assign Overrun = overrun_q;

endmodule

// File: tb/tb_dpram_access_ctrl.sv
// tb_dpram_access_ctrl: directed edge-timing cases plus randomized per-port traffic
// checked against a word-array model; a second instance exercises RD_LAT=3.
module tb_dpram_access_ctrl;
   localparam int AW = 10;
   localparam int DW = 16;
   localparam int MAX_LAT = 2 * (1 + 2);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          ar, RD, WR, B_RD, B_WR, Done, B_Done, Busy, Overrun;
   logic [AW-1:0] A, B_A;
   logic [DW-1:0] DIn, B_DIn, DOut, B_DOut;

   logic          ar3, RD3, WR3, Done3, B_Done3, Busy3, Overrun3;
   logic [AW-1:0] A3;
   logic [DW-1:0] DIn3, DOut3, B_DOut3;

   dpram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
      .clk(clk), .ar(ar),
      .A(A), .DIn(DIn), .RD(RD), .WR(WR), .DOut(DOut), .Done(Done),
      .B_A(B_A), .B_DIn(B_DIn), .B_RD(B_RD), .B_WR(B_WR), .B_DOut(B_DOut), .B_Done(B_Done),
      .Busy(Busy), .Overrun(Overrun)
   );

   dpram_access_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (
      .clk(clk), .ar(ar3),
      .A(A3), .DIn(DIn3), .RD(RD3), .WR(WR3), .DOut(DOut3), .Done(Done3),
      .B_A('0), .B_DIn('0), .B_RD(1'b0), .B_WR(1'b0), .B_DOut(B_DOut3), .B_Done(B_Done3),
      .Busy(Busy3), .Overrun(Overrun3)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [DW-1:0] ref_mem [1024];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Completion-pulse rules watched for the whole run.
   int   both_hi = 0, dbl_done = 0;
   logic done_d = 1'b0, bdone_d = 1'b0;
   always @(negedge clk) begin
      if (Done === 1'b1 && B_Done === 1'b1) both_hi <= both_hi + 1;
      if ((Done === 1'b1 && done_d) || (B_Done === 1'b1 && bdone_d)) dbl_done <= dbl_done + 1;
      done_d  <= (Done === 1'b1);
      bdone_d <= (B_Done === 1'b1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One access on dut; lat = index of the edge (strobe edge = 0) after which Done was seen.
   task automatic do_op(input bit port, input bit is_wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, output int lat, output logic [DW-1:0] rdata);
      bit seen = 1'b0;
      lat = -1;
      rdata = '0;
      if (!port) begin A = addr; DIn = data; if (is_wr) WR = 1'b1; else RD = 1'b1; end
      else begin B_A = addr; B_DIn = data; if (is_wr) B_WR = 1'b1; else B_RD = 1'b1; end
      for (int k = 0; k < 16 && !seen; k++) begin
         tick();
         if (port ? B_Done : Done) begin
            seen = 1'b1;
            lat = k;
            rdata = port ? B_DOut : DOut;
         end
      end
      if (!port) begin RD = 1'b0; WR = 1'b0; end
      else begin B_RD = 1'b0; B_WR = 1'b0; end
      tick();
      check(port ? "b_op_done" : "p0_op_done", {31'd0, seen}, 32'd1);
   endtask

   task automatic op3(input bit is_wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      output int lat, output logic [DW-1:0] rdata);
      bit seen = 1'b0;
      lat = -1;
      rdata = '0;
      A3 = addr; DIn3 = data;
      if (is_wr) WR3 = 1'b1; else RD3 = 1'b1;
      for (int k = 0; k < 16 && !seen; k++) begin
         tick();
         if (Done3) begin seen = 1'b1; lat = k; rdata = DOut3; end
      end
      RD3 = 1'b0; WR3 = 1'b0;
      tick();
      check("d3_op_done", {31'd0, seen}, 32'd1);
   endtask

   // Both ports read at once: port 0 -> 0x000 (0x1111), port B -> 0x3FF (0x2222).
   task automatic tie_rd(input int exp0, input int exp1);
      int d0 = -1, d1 = -1;
      logic [DW-1:0] v0 = '0, v1 = '0;
      A = 10'h000; RD = 1'b1; B_A = 10'h3FF; B_RD = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (Done && d0 < 0) begin d0 = k; v0 = DOut; end
         if (B_Done && d1 < 0) begin d1 = k; v1 = B_DOut; end
      end
      RD = 1'b0; B_RD = 1'b0;
      tick();
      check("tie_p0_edge", d0, exp0);
      check("tie_p0_data", v0, 32'h1111);
      check("tie_b_edge", d1, exp1);
      check("tie_b_data", v1, 32'h2222);
   endtask

   // Each port owns a disjoint 16-word window, so its traffic is checked
   // against the model as a plain sequence of reads and writes.
   task automatic rand_port(input bit port, input logic [AW-1:0] base);
      int lat;
      logic [DW-1:0] rd, d;
      logic [AW-1:0] a;
      bit wr;
      for (int i = 0; i < 16; i++) begin
         d = DW'($urandom);
         a = base + AW'(i);
         do_op(port, 1'b1, a, d, lat, rd);
         ref_mem[a] = d;
         check("rnd_init_lat", {31'd0, (lat >= 2 && lat <= MAX_LAT)}, 32'd1);
      end
      for (int i = 0; i < 40; i++) begin
         a  = base + AW'($urandom_range(0, 15));
         d  = DW'($urandom);
         wr = 1'($urandom_range(0, 1));
         do_op(port, wr, a, d, lat, rd);
         if (wr) begin
            ref_mem[a] = d;
            check("rnd_wr_lat", {31'd0, (lat >= 2 && lat <= MAX_LAT)}, 32'd1);
         end else begin
            check("rnd_rd_data", rd, ref_mem[a]);
            check("rnd_rd_lat", {31'd0, (lat >= 3 && lat <= MAX_LAT)}, 32'd1);
         end
         repeat ($urandom_range(0, 2)) tick();
      end
   endtask

   initial begin
      int lat, cnt, d0, d1;
      logic [DW-1:0] rd, v;

      ar = 1'b1; A = '0; DIn = '0; RD = 1'b0; WR = 1'b0;
      B_A = '0; B_DIn = '0; B_RD = 1'b0; B_WR = 1'b0;
      ar3 = 1'b1; A3 = '0; DIn3 = '0; RD3 = 1'b0; WR3 = 1'b0;
      tick(); tick();
      check("rst_dout", DOut, 0);
      check("rst_b_dout", B_DOut, 0);
      check("rst_done", Done, 0);
      check("rst_b_done", B_Done, 0);
      check("rst_busy", Busy, 0);
      check("rst_overrun", Overrun, 0);
      ar = 1'b0; ar3 = 1'b0;
      tick();

      // Uncontended write then read of 0xBEEF at 0x005.
      A = 10'h005; DIn = 16'hBEEF; WR = 1'b1;
      tick(); check("wr_e0_done", Done, 0); check("wr_e0_busy", Busy, 1);
      tick(); check("wr_e1_done", Done, 0);
      tick(); check("wr_e2_done", Done, 1);
      WR = 1'b0;
      tick(); check("wr_e3_done", Done, 0);
      A = 10'h005; RD = 1'b1;
      tick(); tick(); tick(); check("rd_e2_done", Done, 0);
      tick(); check("rd_e3_done", Done, 1); check("rd_e3_dout", DOut, 32'hBEEF);
      RD = 1'b0;
      tick(); check("rd_e4_done", Done, 0); check("rd_dout_held", DOut, 32'hBEEF);
      check("rd_idle_busy", Busy, 0);

      // Simultaneous RD and WR edge: write first, read returns the new word.
      do_op(1'b0, 1'b1, 10'h010, 16'h0000, lat, rd);
      A = 10'h010; DIn = 16'hA5A5; RD = 1'b1; WR = 1'b1;
      cnt = 0; d0 = -1; d1 = -1; v = '0;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (Done) begin
            cnt++;
            if (cnt == 1) d0 = k;
            else begin d1 = k; v = DOut; end
         end
      end
      RD = 1'b0; WR = 1'b0;
      tick();
      check("rdwr_pulses", cnt, 2);
      check("rdwr_wr_edge", d0, 2);
      check("rdwr_rd_edge", d1, 5);
      check("rdwr_data", v, 32'hA5A5);

      // Strobe held high for 8 cycles gives one completion.
      A = 10'h005; RD = 1'b1; cnt = 0;
      repeat (8) begin tick(); if (Done) cnt++; end
      RD = 1'b0;
      tick();
      check("hold_pulses", cnt, 1);
      check("hold_no_ovr", Overrun, 0);

      // Second rise while the read is still pending is dropped and flagged.
      A = 10'h005; RD = 1'b1;
      tick(); RD = 1'b0;
      tick(); RD = 1'b1;
      tick();
      check("ovr_set", Overrun, 1);
      cnt = 0;
      repeat (8) begin tick(); if (Done) cnt++; end
      RD = 1'b0;
      check("ovr_one_done", cnt, 1);
      check("ovr_sticky", Overrun, 1);
      ar = 1'b1;
      tick();
      check("ovr_cleared", Overrun, 0);
      check("rst2_dout", DOut, 0);
      ar = 1'b0;
      tick();

      // Same-address writes right after reset: port 0 wins the tie, B's data persists.
      A = 10'h020; DIn = 16'h1234; WR = 1'b1;
      B_A = 10'h020; B_DIn = 16'h5678; B_WR = 1'b1;
      repeat (8) tick();
      WR = 1'b0; B_WR = 1'b0;
      tick();
      do_op(1'b0, 1'b0, 10'h020, 16'h0, lat, rd);
      check("sameaddr_data", rd, 32'h5678);
      check("sameaddr_lat", lat, 3);
      do_op(1'b0, 1'b0, 10'h005, 16'h0, lat, rd);
      check("persist_after_rst", rd, 32'hBEEF);

      // Round-robin ties: preloads via port B leave last grant on B.
      do_op(1'b1, 1'b1, 10'h000, 16'h1111, lat, rd);
      do_op(1'b1, 1'b1, 10'h3FF, 16'h2222, lat, rd);
      tie_rd(3, 6);
      do_op(1'b0, 1'b0, 10'h000, 16'h0, lat, rd);
      check("p0_solo_read", rd, 32'h1111);
      tie_rd(6, 3);

      // RD_LAT=3 instance: aborted write, read latency, reset during RD_WAIT.
      op3(1'b1, 10'h033, 16'hCAFE, lat, rd);
      check("d3_wr_lat", lat, 2);
      op3(1'b1, 10'h044, 16'h0001, lat, rd);
      A3 = 10'h044; DIn3 = 16'hFFFF; WR3 = 1'b1;
      tick(); tick();
      ar3 = 1'b1; WR3 = 1'b0;
      tick();
      check("d3_abort_wr_done", Done3, 0);
      ar3 = 1'b0;
      tick();
      op3(1'b0, 10'h033, 16'h0, lat, rd);
      check("d3_rd_lat", lat, 5);
      check("d3_rd_data", rd, 32'hCAFE);
      A3 = 10'h033; RD3 = 1'b1;
      tick(); tick(); tick(); tick();
      check("d3_wait_done", Done3, 0);
      ar3 = 1'b1; RD3 = 1'b0;
      tick();
      check("d3_rst_dout", DOut3, 0);
      check("d3_rst_done", Done3, 0);
      check("d3_rst_busy", Busy3, 0);
      check("d3_rst_ovr", Overrun3, 0);
      check("d3_rst_b_dout", B_DOut3, 0);
      check("d3_rst_b_done", B_Done3, 0);
      ar3 = 1'b0;
      cnt = 0;
      repeat (6) begin tick(); if (Done3) cnt++; end
      check("d3_no_done_after_abort", cnt, 0);
      op3(1'b0, 10'h044, 16'h0, lat, rd);
      check("d3_abort_wr_kept_old", rd, 32'h0001);
      op3(1'b0, 10'h033, 16'h0, lat, rd);
      check("d3_data_after_rst", rd, 32'hCAFE);

      // Randomized concurrent traffic on both ports of the RD_LAT=1 instance.
      fork
         rand_port(1'b0, 10'h100);
         rand_port(1'b1, 10'h300);
      join
      tick();
      check("rnd_no_overrun", Overrun, 0);
      check("done_both_high", both_hi, 0);
      check("done_two_cycles", dbl_done, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
